// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared types and constants for the PWM duty ramp sequencer.
// The duty-width default here must track the pwm_controller it drives.
package pwm_ramp_sequencer_pkg;

  localparam int unsigned DefaultSysFreq = 125;
  localparam int unsigned DutyWidth      = 7;
  localparam int unsigned MsCycles       = DefaultSysFreq * 1000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRamp = 2'd1,
    StHold = 2'd2
  } state_e;

  function automatic int unsigned ms_cycles(input int unsigned sys_freq);
    return sys_freq * 1000;
  endfunction

endpackage

// File: rtl/pwm_ramp_sequencer_ms_tick_gen.sv
// Clearable millisecond prescaler: one-cycle tick every SYS_FREQ*1000 clocks.
module pwm_ramp_sequencer_ms_tick_gen
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int unsigned SYS_FREQ = DefaultSysFreq
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned Cycles = ms_cycles(SYS_FREQ);
  localparam int unsigned CntW   = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] CntTop = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q >= CntTop);

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Steps PWM duty one LSB per step_ms toward a commanded target, holds for
// hold_ms, then pulses done. Abort freezes duty and returns to idle.
module pwm_ramp_sequencer
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int unsigned SYS_FREQ = DefaultSysFreq,
  parameter int unsigned N        = DutyWidth,
  parameter int unsigned T_W      = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [N-1:0]   cmd_target,
  input  logic [T_W-1:0] cmd_step_ms,
  input  logic [T_W-1:0] cmd_hold_ms,
  input  logic           abort,
  output logic [N-1:0]   duty,
  output logic           busy,
  output logic           done
);

  state_e         state_q, state_d;
  logic [N-1:0]   duty_q, duty_d;
  logic [N-1:0]   target_q, target_d;
  logic [T_W-1:0] step_ms_q, step_ms_d;
  logic [T_W-1:0] hold_ms_q, hold_ms_d;
  logic [T_W-1:0] step_cnt_q, step_cnt_d;
  logic [T_W-1:0] hold_cnt_q, hold_cnt_d;
  logic           done_q, done_d;

  logic           tick;
  logic           presc_clear;
  logic           accept;
  logic [T_W:0]   step_cnt_inc;
  logic [T_W:0]   hold_cnt_inc;
  logic [N-1:0]   duty_step;

  // Ready stays low during the done cycle so it rises the cycle after.
  assign cmd_ready    = (state_q == StIdle) && reset_n && !done_q;
  assign accept       = cmd_valid && cmd_ready && !abort;
  assign step_cnt_inc = {1'b0, step_cnt_q} + 1'b1;
  assign hold_cnt_inc = {1'b0, hold_cnt_q} + 1'b1;
  assign duty_step    = (duty_q > target_q) ? duty_q - 1'b1 : duty_q + 1'b1;

  // Every state change (accept included) restarts the ms prescaler.
  assign presc_clear = (state_d != state_q);

  pwm_ramp_sequencer_ms_tick_gen #(
    .SYS_FREQ (SYS_FREQ)
  ) u_ms_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (presc_clear),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    step_ms_d  = step_ms_q;
    hold_ms_d  = hold_ms_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          target_d   = cmd_target;
          step_ms_d  = cmd_step_ms;
          hold_ms_d  = cmd_hold_ms;
          step_cnt_d = '0;
          hold_cnt_d = '0;
          state_d    = (cmd_target == duty_q) ? StHold : StRamp;
        end
      end
      StRamp: begin
        if (abort) begin
          state_d = StIdle;
        end else if (step_ms_q == '0) begin
          duty_d  = target_q;
          state_d = StHold;
        end else if (tick) begin
          if (step_cnt_inc >= {1'b0, step_ms_q}) begin
            step_cnt_d = '0;
            duty_d     = duty_step;
            if (duty_step == target_q) begin
              state_d = StHold;
            end
          end else begin
            step_cnt_d = step_cnt_inc[T_W-1:0];
          end
        end
      end
      StHold: begin
        if (abort) begin
          state_d = StIdle;
        end else if ((hold_ms_q == '0) || (tick && (hold_cnt_inc >= {1'b0, hold_ms_q}))) begin
          state_d    = StIdle;
          done_d     = 1'b1;
          hold_cnt_d = '0;
        end else if (tick) begin
          hold_cnt_d = hold_cnt_inc[T_W-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      duty_q     <= '0;
      target_q   <= '0;
      step_ms_q  <= '0;
      hold_ms_q  <= '0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_ms_q  <= step_ms_d;
      hold_ms_q  <= hold_ms_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
    end
  end

  assign duty = duty_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench: the driver predicts every duty change and done pulse with
// its cycle; a monitor pops and compares whenever the DUT output moves.
module tb_pwm_ramp_sequencer;

  localparam int unsigned SysFreq = 1;
  localparam int unsigned N       = 7;
  localparam int unsigned TW      = 16;
  localparam int unsigned M       = SysFreq * 1000;

  typedef struct {
    int unsigned cyc;
    bit          is_done;
    int          duty;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  cmd_target = '0;
  logic [TW-1:0] cmd_step_ms = '0;
  logic [TW-1:0] cmd_hold_ms = '0;
  logic          cmd_ready;
  logic [N-1:0]  duty;
  logic          busy;
  logic          done;

  ev_t         exp_q[$];
  ev_t         plan[$];
  int unsigned cyc = 0;
  int unsigned last_a = 0;
  int          last_d0 = 0;
  int          model_duty = 0;
  int          nchk = 0;
  int          nerr = 0;
  bit          chk_ready_next = 1'b0;

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(
    .SYS_FREQ (SysFreq),
    .N        (N),
    .T_W      (TW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .cmd_step_ms (cmd_step_ms),
    .cmd_hold_ms (cmd_hold_ms),
    .abort       (abort),
    .duty        (duty),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int unsigned c, input bit d, input int v);
    ev_t e;
    e.cyc = c;
    e.is_done = d;
    e.duty = v;
    exp_q.push_back(e);
    plan.push_back(e);
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    ev_t  e;
    logic [N-1:0] prev_duty;
    prev_duty = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (chk_ready_next) begin
        chk_ready_next = 1'b0;
        check("ready_after_done", cmd_ready, 1);
      end
      if (!reset_n) begin
        prev_duty = duty;
        continue;
      end
      if (duty !== prev_duty || done !== 1'b0) begin
        nchk++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_output: got duty=%0d done=%b at cycle %0d, none expected",
                   duty, done, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || done !== e.is_done || duty !== N'(e.duty)) begin
            nerr++;
            $display("FAIL event: got cyc=%0d done=%b duty=%0d expected cyc=%0d done=%b duty=%0d",
                     cyc, done, duty, e.cyc, e.is_done, e.duty);
          end
        end
        if (done === 1'b1) begin
          check("busy_at_done", busy, 0);
          check("ready_at_done", cmd_ready, 0);
          chk_ready_next = 1'b1;
        end else begin
          check("busy_in_ramp", busy, 1);
        end
      end
      prev_duty = duty;
    end
  end

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) check("ready_timeout", cmd_ready, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd_ready !== 1'b1) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30000) begin
      nchk++;
      nerr++;
      $display("FAIL %s_timeout: got %0d events outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input int ncyc);
    reset_n = 1'b0;
    exp_q.delete();
    chk_ready_next = 1'b0;
    model_duty = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check("reset_duty", duty, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_ready", cmd_ready, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);
    check("duty_after_reset", duty, 0);
  endtask

  // Predicts the full event timeline of one command from its rules.
  task automatic send(input int t, input int s, input int h);
    int unsigned a, hs;
    int d0, n, dir;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_target = N'(t);
    cmd_step_ms = TW'(s);
    cmd_hold_ms = TW'(h);
    @(negedge clk);
    a = cyc;
    cmd_valid = 1'b0;
    cmd_target = N'($urandom);
    cmd_step_ms = TW'($urandom);
    cmd_hold_ms = TW'($urandom);
    check("busy_after_accept", busy, 1);
    d0 = model_duty;
    n = (t > d0) ? t - d0 : d0 - t;
    dir = (t > d0) ? 1 : -1;
    plan.delete();
    last_a = a;
    last_d0 = d0;
    if (n == 0) begin
      hs = a;
    end else if (s == 0) begin
      push(a + 1, 1'b0, t);
      hs = a + 1;
    end else begin
      for (int k = 1; k <= n; k++) push(a + k * s * M, 1'b0, d0 + dir * k);
      hs = a + n * s * M;
    end
    push((h == 0) ? hs + 1 : hs + h * M, 1'b1, t);
    model_duty = t;
  endtask

  // Abort with a competing command in the same cycle; neither later event nor
  // the competing command may take effect.
  task automatic do_abort(input int t2);
    int unsigned c;
    c = cyc;
    cmd_valid = 1'b1;
    cmd_target = N'(t2);
    cmd_step_ms = '0;
    cmd_hold_ms = '0;
    abort = 1'b1;
    while (exp_q.size() != 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
    model_duty = last_d0;
    foreach (plan[i]) if (!plan[i].is_done && plan[i].cyc <= c) model_duty = plan[i].duty;
    @(negedge clk);
    abort = 1'b0;
    cmd_valid = 1'b0;
    check("busy_after_abort", busy, 0);
    check("duty_after_abort", duty, model_duty);
    check("ready_after_abort", cmd_ready, 1);
  endtask

  initial begin
    int t, s, h;
    @(negedge clk);
    do_reset(3);

    send(5, 2, 3);
    wait_idle("ramp_up");
    send(2, 1, 0);
    wait_idle("ramp_down");
    send(127, 0, 0);
    wait_idle("immediate");
    send(127, 0, 1);
    wait_idle("equal_target");

    // Reset in the middle of a ramp at duty 4.
    send(0, 0, 0);
    wait_idle("to_zero");
    send(10, 1, 0);
    wait_until(last_a + 4 * M + 500);
    check("duty_before_reset", duty, 4);
    do_reset(3);

    // Abort at duty 3 while heading for 10.
    send(10, 1, 5);
    wait_until(last_a + 3 * M + 500);
    check("duty_before_abort", duty, 3);
    do_abort(20);
    check("abort_froze_at_3", duty, 3);
    send(6, 0, 2);
    wait_idle("after_abort");

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ready", cmd_ready, 1);
    check("idle_abort_duty", duty, 6);

    for (int i = 0; i < 8; i++) begin
      t = model_duty + int'($urandom_range(0, 6)) - 3;
      if (t < 0) t = 0;
      if (t > 127) t = 127;
      s = int'($urandom_range(0, 2));
      h = int'($urandom_range(0, 2));
      send(t, s, h);
      if ($urandom_range(0, 3) == 0) begin
        wait_until(last_a + $urandom_range(1, 3000));
        if (exp_q.size() != 0) do_abort(int'($urandom_range(0, 127)));
      end
      wait_idle("random");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
